// File: rtl/pc_pkg.sv
// pc_pkg: shared PC sequencer FSM encoding and fall-through increment
package pc_pkg;
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
  localparam int PC_INCR = 4;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/branch inputs and PC outputs of the PC sequencer
// master drives Stall/Flush/branch controls/SignExtImm/RegTarget and observes CurrentPC/NextPC/Taken/Pending; slave is the sequencer side
interface pc_sequencer_if #(parameter int WIDTH = 64);
  logic Stall, Flush, Branch, BranchNZ, ALUZero, Uncondbranch, RegJump;
  logic [WIDTH-1:0] SignExtImm, RegTarget, CurrentPC, NextPC;
  logic Taken, Pending;
  modport master (
    output Stall, Flush, Branch, BranchNZ, ALUZero, Uncondbranch, RegJump, SignExtImm, RegTarget,
    input  CurrentPC, NextPC, Taken, Pending
  );
  modport slave (
    input  Stall, Flush, Branch, BranchNZ, ALUZero, Uncondbranch, RegJump, SignExtImm, RegTarget,
    output CurrentPC, NextPC, Taken, Pending
  );
endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational branch target and fall-through PC
// pc_i current PC, imm_i word offset, reg_target_i BR target, reg_jump_i selects BR; target_o redirect PC, fall_through_o PC+4
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int IMM_SHIFT = 2
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] imm_i,
  input  logic [WIDTH-1:0] reg_target_i,
  input  logic             reg_jump_i,
  output logic [WIDTH-1:0] target_o,
  output logic [WIDTH-1:0] fall_through_o
);
  always_comb begin
    target_o       = reg_jump_i ? reg_target_i : pc_i + (imm_i << IMM_SHIFT);
    fall_through_o = pc_i + WIDTH'(PC_INCR);
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch redirect, stall-deferred redirect and flush
// CLK rising-edge clock, resetl async active-low reset, bus slave modport carries controls and PC outputs
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int             WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int             IMM_SHIFT = 2
) (
  input logic CLK,
  input logic resetl,
  pc_sequencer_if.slave bus
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, tgt_q, tgt_d, target, fall_through;
  logic taken;
  pc_target_calc #(.WIDTH(WIDTH), .IMM_SHIFT(IMM_SHIFT)) u_calc (
    .pc_i           (pc_q),
    .imm_i          (bus.SignExtImm),
    .reg_target_i   (bus.RegTarget),
    .reg_jump_i     (bus.RegJump),
    .target_o       (target),
    .fall_through_o (fall_through)
  );
  assign taken = bus.RegJump | bus.Uncondbranch | (bus.Branch & (bus.ALUZero ^ bus.BranchNZ));
  // In HOLD the branch inputs are ignored: the first latched target wins.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    if (bus.Flush) begin
      state_d = RUN;
      pc_d    = RESET_PC;
    end else if (state_q == HOLD) begin
      state_d = bus.Stall ? HOLD : RUN;
      pc_d    = bus.Stall ? pc_q : tgt_q;
    end else if (!bus.Stall) begin
      pc_d = taken ? target : fall_through;
    end else if (taken) begin
      state_d = HOLD;
      tgt_d   = target;
    end
  end
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end
  assign bus.CurrentPC = pc_q;
  assign bus.NextPC    = pc_d;
  assign bus.Taken     = taken;
  assign bus.Pending   = state_q == HOLD;
endmodule
